// File: rtl/cpu7_ifu_ibuf_if.sv
// cpu7_ifu_ibuf_if: fetch-fill and decode-issue signal bundle of the cpu7 IFU instruction buffer.
// master = fetch/decode side, slave = the buffer.
`ifndef GRLEN
`define GRLEN 32
`endif
interface cpu7_ifu_ibuf_if #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 4,
    parameter int ISSUE_W = 2
);
    logic                          fill_valid;
    logic                          fill_ready;
    logic [`GRLEN-1:0]             fill_pc;
    logic [$clog2(FETCH_W)-1:0]    fill_count;
    logic [32*FETCH_W-1:0]         fill_data;
    logic                          fill_ex;
    logic [5:0]                    fill_exccode;
    logic                          flush;
    logic                          stall;
    logic [$clog2(ISSUE_W):0]      dec_accept;
    logic [ISSUE_W-1:0]            ibuf_dec_valid;
    logic [32*ISSUE_W-1:0]         ibuf_dec_inst;
    logic [`GRLEN*ISSUE_W-1:0]     ibuf_dec_pc;
    logic [ISSUE_W-1:0]            ibuf_dec_ex;
    logic [6*ISSUE_W-1:0]          ibuf_dec_exccode;
    logic [$clog2(DEPTH):0]        ibuf_count;

    modport master (
        output fill_valid, fill_pc, fill_count, fill_data, fill_ex, fill_exccode,
               flush, stall, dec_accept,
        input  fill_ready, ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex,
               ibuf_dec_exccode, ibuf_count
    );
    modport slave (
        input  fill_valid, fill_pc, fill_count, fill_data, fill_ex, fill_exccode,
               flush, stall, dec_accept,
        output fill_ready, ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex,
               ibuf_dec_exccode, ibuf_count
    );
endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// cpu7_ifu_ibuf: circular instruction buffer between fetch and decode of the cpu7 IFU.
// Define CPU7_IBUF_BYPASS_EN to present a fill into an empty buffer in the same cycle.
`ifndef GRLEN
`define GRLEN 32
`endif
module cpu7_ifu_ibuf #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 4,
    parameter int ISSUE_W = 2
) (
    input logic            clock,
    input logic            resetn,
    cpu7_ifu_ibuf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = `GRLEN;

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];
    logic [GW-1:0]    pc_q   [DEPTH];
    logic [GW-1:0]    pc_d   [DEPTH];
    logic [5:0]       exc_q  [DEPTH];
    logic [5:0]       exc_d  [DEPTH];
    logic [DEPTH-1:0] ex_q, ex_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pend_q, pend_d;
    logic             wr, byp;
    logic [CW-1:0]    n, pop, sh, wn;

    assign bus.fill_ready = ~pend_q & (CW'(DEPTH) - count_q >= CW'(FETCH_W));
    assign bus.ibuf_count = count_q;
    assign wr  = bus.fill_valid & bus.fill_ready & ~bus.flush;
    assign n   = bus.fill_ex ? CW'(1) : CW'(bus.fill_count) + CW'(1);
    assign pop = bus.stall ? '0 : CW'(bus.dec_accept);
`ifdef CPU7_IBUF_BYPASS_EN
    // Into an empty buffer the fill drives the slots itself; accepted ones are never stored.
    assign byp = wr & (count_q == '0);
`else
    assign byp = 1'b0;
`endif
    assign sh = byp ? pop : '0;
    assign wn = wr ? n - sh : '0;

    always_comb begin
        inst_d = inst_q;
        pc_d   = pc_q;
        exc_d  = exc_q;
        ex_d   = ex_q;
        for (int i = 0; i < FETCH_W; i++) begin
            int j;
            j = i + int'(sh);
            if (wr && j < int'(n)) begin
                inst_d[tail_q + AW'(i)] = bus.fill_ex ? '0 : bus.fill_data[32*j +: 32];
                pc_d[tail_q + AW'(i)]   = bus.fill_pc + GW'(4 * j);
                exc_d[tail_q + AW'(i)]  = bus.fill_ex ? bus.fill_exccode : '0;
                ex_d[tail_q + AW'(i)]   = bus.fill_ex;
            end
        end
        head_d  = head_q + (byp ? '0 : AW'(pop));
        tail_d  = tail_q + AW'(wn);
        count_d = count_q + wn - (byp ? '0 : pop);
        pend_d  = pend_q | (wr & bus.fill_ex);
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            bus.ibuf_dec_valid[k]          = CW'(k) < count_q;
            bus.ibuf_dec_inst[32*k +: 32]  = inst_q[head_q + AW'(k)];
            bus.ibuf_dec_pc[GW*k +: GW]    = pc_q[head_q + AW'(k)];
            bus.ibuf_dec_ex[k]             = ex_q[head_q + AW'(k)];
            bus.ibuf_dec_exccode[6*k +: 6] = exc_q[head_q + AW'(k)];
            if (byp) begin
                bus.ibuf_dec_valid[k]          = CW'(k) < n;
                bus.ibuf_dec_inst[32*k +: 32]  = bus.fill_ex ? '0 : bus.fill_data[32*(k % FETCH_W) +: 32];
                bus.ibuf_dec_pc[GW*k +: GW]    = bus.fill_pc + GW'(4 * k);
                bus.ibuf_dec_ex[k]             = bus.fill_ex;
                bus.ibuf_dec_exccode[6*k +: 6] = bus.fill_exccode;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                exc_q[i]  <= '0;
            end
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            ex_q    <= ex_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: doc/cpu7_ifu_ibuf.md
# cpu7_ifu_ibuf

Parametrised instruction buffer between the fetch datapath and the decoder in the cpu7 IFU. It accepts multi-instruction fetch responses of up to FETCH_W instructions per cycle and presents up to ISSUE_W in-order instructions per cycle to decode. Each presented instruction carries its PC and exception status. The block is flushed on branch cancel, and once an exception response is captured it blocks further fills until the next flush.

## Interface
- DEPTH, 8: entry count; power of two; DEPTH ≥ FETCH_W and DEPTH ≥ ISSUE_W.
- FETCH_W, 4: instructions per fetch response; power of two.
- ISSUE_W, 2: instructions presented to decode per cycle.
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- fill_valid  in  1  a fetch response is present.
- fill_ready  out  1  buffer can accept a response; write when fill_valid & fill_ready.
- fill_pc  in  `GRLEN  PC of instruction 0 of the response.
- fill_count  in  clog2(FETCH_W)  number of valid instructions minus 1.
- fill_data  in  32*FETCH_W  instruction i at [32i+31:32i].
- fill_ex  in  1  response carries a fetch exception.
- fill_exccode  in  6  exception code.
- flush  in  1  branch cancel; discards all contents.
- stall  in  1  decode stall; no entry leaves while high.
- dec_accept  in  clog2(ISSUE_W)+1  number of presented slots consumed this cycle.
- ibuf_dec_valid  out  ISSUE_W  per-slot valid; always a prefix (slot 0 first).
- ibuf_dec_inst  out  32*ISSUE_W  per-slot instruction.
- ibuf_dec_pc  out  `GRLEN*ISSUE_W  per-slot PC.
- ibuf_dec_ex  out  ISSUE_W  per-slot exception flag.
- ibuf_dec_exccode  out  6*ISSUE_W  per-slot exception code.
- ibuf_count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Circular storage of DEPTH entries {inst, pc, ex, exccode}, with head and tail pointers modulo DEPTH and an occupancy counter.
- Normal fill writes n = fill_count+1 entries at tail..tail+n-1 (wrapping). Entry i gets pc = fill_pc + 4*i (`GRLEN-bit wrap), ex = 0.
- Exception fill (fill_ex=1) writes exactly one entry: inst = 0, pc = fill_pc, ex = 1, exccode = fill_exccode. fill_count is ignored. The write sets ex_pending.
- fill_ready = !ex_pending & (DEPTH − ibuf_count ≥ FETCH_W). It ignores any same-cycle pop (conservative).
- Slot k is valid iff k < ibuf_count. Slot k shows entry head+k. Payload fields of invalid slots are don't-care.
- Pop: when !stall, head += dec_accept and the count decreases by dec_accept. When stall=1, dec_accept is ignored.
- dec_accept greater than the number of valid slots is illegal (bench assertion).
- Fill and pop in the same cycle: count_next = count + n − accept.
- Flush has top priority. Head, tail, count and ex_pending go to 0, and any same-cycle fill and accept are discarded.

## Timing
- Reset values: head = tail = count = 0, ex_pending = 0.
- Outputs during and after reset: ibuf_dec_valid = 0, ibuf_count = 0, fill_ready = 1.
- Fill-to-present latency is 1 cycle: a write at edge t is visible on the slots after t.
- Pop takes effect at the edge; the next entries are presented in the following cycle.
- After flush, ibuf_dec_valid = 0 and fill_ready = 1 in the next cycle.
- Assertion of resetn mid-operation clears all state asynchronously, with no partial writes.
- All outputs except fill_ready and the slot bypass path are register-derived.

## Configuration
- CPU7_IBUF_BYPASS_EN defined:
  - When count = 0 and a normal fill is written, fill instructions 0..min(n,ISSUE_W)−1 appear combinationally on the slots in the same cycle.
  - Up to that many may be accepted that cycle. Accepted instructions are not stored; only the remainder is written.
  - Exception fills bypass as a single ex slot.
  - Flush suppresses the bypass.
- CPU7_IBUF_BYPASS_EN undefined: no bypass; the latency is always 1 cycle.

## Test plan
All scenarios use DEPTH=8, FETCH_W=4, ISSUE_W=2, no bypass.
- **In-order fill and drain:** fill pc=0x1c000000, count=3, data A,B,C,D; accept=2 each cycle.
  - Next cycle: slots A@0x1c000000, B@0x1c000004.
  - Cycle after: C@0x1c000008, D@0x1c00000c.
  - ibuf_count goes 4, 2, 0.
- **Full / ready:** two 4-instruction fills with no accept → ibuf_count=8, fill_ready=0. Accept 2 → count 6, fill_ready still 0. Accept 2 → count 4, fill_ready=1.
- **Wrap-around with simultaneous fill and pop:** 5 fills of 4 instructions, interleaved with accept=2 every cycle for 10 cycles.
  - PCs emerge strictly sequentially with step 4 across the pointer wrap.
  - ibuf_count never exceeds 8.
- **Flush priority:** with count=4, flush=1 together with a valid fill and accept=2 → next cycle count=0, valid=0, fill_ready=1. The fill's instructions never appear.
- **Exception:** fill_ex=1, exccode=0x08, pc=0x1c000040, count=3 → one slot with ex=1, pc=0x1c000040, inst=0.
  - fill_ready stays 0 after that slot is accepted, until flush.
- **Stall:** with count=4, stall=1 and accept=2 for 3 cycles → head unchanged, count=4. Release → A and B are consumed on the next edge.
  - With CPU7_IBUF_BYPASS_EN: a fill into an empty buffer shows A and B in the same cycle; accept=2 → count=2 next cycle.
